// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_stage
//  Description : RV32I issue / operand-fetch stage in front of a registered
//                single-cycle ALU. Accepts decoded ALU instructions, reads a
//                local register file with forwarding from the in-flight ALU
//                result, builds op1/op2 and writes the result back one cycle
//                after issue.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int TRACE = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            hold,
    output logic [31:0]     alu_instr,
    output logic [XLEN-1:0] alu_op1,
    output logic [XLEN-1:0] alu_op2,
    output logic            alu_enable,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_instr_exec,
    output logic            illegal,
    output logic [15:0]     issued_cnt
);

    localparam logic [6:0] c_OPC_OP    = 7'b0110011;
    localparam logic [6:0] c_OPC_IMM   = 7'b0010011;
    localparam logic [6:0] c_OPC_LUI   = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC = 7'b0010111;

    // Instruction fields
    logic [6:0]      w_opcode;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_u;

    // Handshake / issue
    logic            w_transfer;
    logic            w_is_alu;
    logic            w_issue;

    // Operand datapath
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;

    // Register file and pending writeback
    logic [XLEN-1:0] r_regs [NREGS];
    logic            r_pend_valid;
    logic [4:0]      r_pend_rd;
    logic            w_wb_en;

    // Registered status outputs
    logic            r_illegal;
    logic [15:0]     r_issued_cnt;

    assign w_opcode = in_instr[6:0];
    assign w_rd     = in_instr[11:7];
    assign w_rs1    = in_instr[19:15];
    assign w_rs2    = in_instr[24:20];
    assign w_imm_i  = XLEN'($signed(in_instr[31:20]));
    assign w_imm_u  = XLEN'($signed({in_instr[31:12], 12'b0}));

    assign in_ready   = !hold;
    // Nothing is accepted while reset is asserted, so reset fully owns the cycle.
    assign w_transfer = in_valid && in_ready && !rst;
    assign w_issue    = w_transfer && w_is_alu;

    // The in-flight result is only trusted (for both write and forward) when
    // the ALU confirms it executed; rd==x0 never produces a value.
    assign w_wb_en = r_pend_valid && alu_instr_exec && (r_pend_rd != 5'd0);

    // Register reads with x0 hardwired to zero and bypass from the ALU result.
    always_comb begin
        w_rs1_val = '0;
        w_rs2_val = '0;
        if (w_rs1 != 5'd0) begin
            w_rs1_val = (w_wb_en && (w_rs1 == r_pend_rd)) ? alu_result : r_regs[w_rs1];
        end
        if (w_rs2 != 5'd0) begin
            w_rs2_val = (w_wb_en && (w_rs2 == r_pend_rd)) ? alu_result : r_regs[w_rs2];
        end
    end

    // Opcode classification and operand selection.
    always_comb begin
        w_is_alu = 1'b0;
        w_op1    = '0;
        w_op2    = '0;
        case (w_opcode)
            c_OPC_OP: begin
                w_is_alu = 1'b1;
                w_op1    = w_rs1_val;
                w_op2    = w_rs2_val;
            end
            c_OPC_IMM: begin
                w_is_alu = 1'b1;
                w_op1    = w_rs1_val;
                w_op2    = w_imm_i;
            end
            c_OPC_LUI: begin
                w_is_alu = 1'b1;
                w_op1    = w_imm_u;
                w_op2    = '0;
            end
            c_OPC_AUIPC: begin
                w_is_alu = 1'b1;
                w_op1    = w_imm_u;
                w_op2    = in_pc;
            end
            default: begin
                w_is_alu = 1'b0;
            end
        endcase
    end

    // ALU drive is combinational in the issue cycle and quiet otherwise.
    assign alu_enable = w_issue;
    assign alu_instr  = w_issue ? in_instr : 32'd0;
    assign alu_op1    = w_issue ? w_op1 : '0;
    assign alu_op2    = w_issue ? w_op2 : '0;

    // Register file: cleared on reset, written one cycle after issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_en) begin
            r_regs[r_pend_rd] <= alu_result;
        end
    end

    // Pending writeback tracker: lives exactly one cycle unless re-armed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_valid <= 1'b0;
            r_pend_rd    <= 5'd0;
        end else if (w_issue) begin
            r_pend_valid <= 1'b1;
            r_pend_rd    <= w_rd;
        end else begin
            r_pend_valid <= 1'b0;
        end
    end

    // Illegal pulse and issue counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal    <= 1'b0;
            r_issued_cnt <= 16'd0;
        end else begin
            r_illegal <= w_transfer && !w_is_alu;
            if (w_issue) begin
                r_issued_cnt <= r_issued_cnt + 16'd1;
            end
        end
    end

    assign illegal    = r_illegal;
    assign issued_cnt = r_issued_cnt;

`ifndef SYNTHESIS
    generate
        if (TRACE != 0) begin : g_trace
            // Simulation-only issue log.
            always_ff @(posedge clk) begin
                if (w_issue) begin
                    $display("[%0t] issue pc=%h instr=%h", $time, in_pc, in_instr);
                end
            end
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_operand_stage
//  Description : Self-checking bench for alu_operand_stage with a small
//                registered-adder ALU model driving alu_result/alu_instr_exec.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        hold;
    logic [31:0] alu_instr;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic        alu_enable;
    logic [31:0] alu_result;
    logic        alu_instr_exec;
    logic        illegal;
    logic [15:0] issued_cnt;
    logic        drop;

    int n_checks;
    int n_fail;

    alu_operand_stage #(
        .XLEN  (32),
        .NREGS (32),
        .TRACE (0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instr       (in_instr),
        .in_pc          (in_pc),
        .hold           (hold),
        .alu_instr      (alu_instr),
        .alu_op1        (alu_op1),
        .alu_op2        (alu_op2),
        .alu_enable     (alu_enable),
        .alu_result     (alu_result),
        .alu_instr_exec (alu_instr_exec),
        .illegal        (illegal),
        .issued_cnt     (issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ALU model: every instruction used here is an add of op1/op2.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result     <= 32'd0;
            alu_instr_exec <= 1'b0;
        end else begin
            alu_result     <= alu_op1 + alu_op2;
            alu_instr_exec <= alu_enable && !drop;
        end
    end

    // Instruction encoders
    function automatic logic [31:0] f_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] f_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] f_lui(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'b0110111};
    endfunction
    function automatic logic [31:0] f_auipc(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'b0010111};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the edge, then settle mid-cycle.
    task automatic apply(input logic v, input logic h, input logic [31:0] ins, input logic [31:0] pc);
        @(posedge clk);
        #1;
        in_valid = v;
        hold     = h;
        in_instr = ins;
        in_pc    = pc;
        #3;
    endtask

    typedef struct {
        logic        valid;
        logic        hold;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        en;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        ill;
        logic [15:0] cnt;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        hold     = 1'b0;
        in_instr = 32'd0;
        in_pc    = 32'd0;
        drop     = 1'b0;

        //              valid hold  instr                          pc       en    op1           op2           ill   cnt
        vecs[0]  = '{1'b1, 1'b0, f_addi(5'd1, 5'd0, 12'd5),      32'h0,   1'b1, 32'd0,        32'd5,        1'b0, 16'd0};
        vecs[1]  = '{1'b1, 1'b0, f_addi(5'd2, 5'd0, 12'd7),      32'h4,   1'b1, 32'd0,        32'd7,        1'b0, 16'd1};
        vecs[2]  = '{1'b0, 1'b0, 32'd0,                          32'h0,   1'b0, 32'd0,        32'd0,        1'b0, 16'd2};
        vecs[3]  = '{1'b1, 1'b0, f_add(5'd3, 5'd1, 5'd2),        32'h8,   1'b1, 32'd5,        32'd7,        1'b0, 16'd2};
        vecs[4]  = '{1'b1, 1'b0, f_addi(5'd1, 5'd0, 12'd10),     32'hC,   1'b1, 32'd0,        32'd10,       1'b0, 16'd3};
        vecs[5]  = '{1'b1, 1'b0, f_add(5'd2, 5'd1, 5'd1),        32'h10,  1'b1, 32'd10,       32'd10,       1'b0, 16'd4};
        vecs[6]  = '{1'b1, 1'b0, f_add(5'd7, 5'd3, 5'd0),        32'h14,  1'b1, 32'd12,       32'd0,        1'b0, 16'd5};
        vecs[7]  = '{1'b1, 1'b0, f_addi(5'd4, 5'd0, 12'hFFF),    32'h18,  1'b1, 32'd0,        32'hFFFFFFFF, 1'b0, 16'd6};
        vecs[8]  = '{1'b1, 1'b0, f_lui(5'd5, 20'h12345),         32'h1C,  1'b1, 32'h12345000, 32'd0,        1'b0, 16'd7};
        vecs[9]  = '{1'b1, 1'b0, f_auipc(5'd8, 20'h00001),       32'h100, 1'b1, 32'h00001000, 32'h100,      1'b0, 16'd8};
        vecs[10] = '{1'b1, 1'b0, f_addi(5'd0, 5'd0, 12'd9),      32'h104, 1'b1, 32'd0,        32'd9,        1'b0, 16'd9};
        vecs[11] = '{1'b1, 1'b0, f_add(5'd6, 5'd0, 5'd0),        32'h108, 1'b1, 32'd0,        32'd0,        1'b0, 16'd10};
        vecs[12] = '{1'b1, 1'b0, 32'h0000006F,                   32'h10C, 1'b0, 32'd0,        32'd0,        1'b0, 16'd11};
        vecs[13] = '{1'b0, 1'b0, 32'd0,                          32'h0,   1'b0, 32'd0,        32'd0,        1'b1, 16'd11};
        vecs[14] = '{1'b0, 1'b0, 32'd0,                          32'h0,   1'b0, 32'd0,        32'd0,        1'b0, 16'd11};
        vecs[15] = '{1'b1, 1'b0, f_add(5'd9, 5'd2, 5'd5),        32'h110, 1'b1, 32'd20,       32'h12345000, 1'b0, 16'd11};
        vecs[16] = '{1'b1, 1'b0, f_add(5'd10, 5'd4, 5'd8),       32'h114, 1'b1, 32'hFFFFFFFF, 32'h00001100, 1'b0, 16'd12};

        // Reset state
        repeat (3) @(posedge clk);
        #4;
        chk("rst_enable",  {31'd0, alu_enable}, 32'd0);
        chk("rst_instr",   alu_instr,           32'd0);
        chk("rst_op1",     alu_op1,             32'd0);
        chk("rst_op2",     alu_op2,             32'd0);
        chk("rst_illegal", {31'd0, illegal},    32'd0);
        chk("rst_cnt",     {16'd0, issued_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table-driven vectors, one row per cycle
        for (int i = 0; i < NV; i++) begin
            apply(vecs[i].valid, vecs[i].hold, vecs[i].instr, vecs[i].pc);
            chk($sformatf("v%0d_ready", i),   {31'd0, in_ready},   {31'd0, !vecs[i].hold});
            chk($sformatf("v%0d_enable", i),  {31'd0, alu_enable}, {31'd0, vecs[i].en});
            chk($sformatf("v%0d_instr", i),   alu_instr,           vecs[i].en ? vecs[i].instr : 32'd0);
            chk($sformatf("v%0d_op1", i),     alu_op1,             vecs[i].op1);
            chk($sformatf("v%0d_op2", i),     alu_op2,             vecs[i].op2);
            chk($sformatf("v%0d_illegal", i), {31'd0, illegal},    {31'd0, vecs[i].ill});
            chk($sformatf("v%0d_cnt", i),     {16'd0, issued_cnt}, {16'd0, vecs[i].cnt});
        end

        // Hold: writeback of x11 still lands while issue is frozen
        apply(1'b1, 1'b0, f_addi(5'd11, 5'd0, 12'd33), 32'h200);
        chk("hold_pre_enable", {31'd0, alu_enable}, 32'd1);
        chk("hold_pre_cnt",    {16'd0, issued_cnt}, 32'd13);
        for (int k = 0; k < 3; k++) begin
            apply(1'b1, 1'b1, f_add(5'd12, 5'd11, 5'd11), 32'h204);
            chk($sformatf("hold%0d_ready", k),  {31'd0, in_ready},   32'd0);
            chk($sformatf("hold%0d_enable", k), {31'd0, alu_enable}, 32'd0);
            chk($sformatf("hold%0d_instr", k),  alu_instr,           32'd0);
            chk($sformatf("hold%0d_cnt", k),    {16'd0, issued_cnt}, 32'd14);
        end
        apply(1'b1, 1'b0, f_add(5'd12, 5'd11, 5'd11), 32'h204);
        chk("hold_rel_enable", {31'd0, alu_enable}, 32'd1);
        chk("hold_rel_op1",    alu_op1,             32'd33);
        chk("hold_rel_op2",    alu_op2,             32'd33);

        // Dropped write: ALU reports no execution, no forward and no write
        drop = 1'b1;
        apply(1'b1, 1'b0, f_addi(5'd13, 5'd0, 12'd44), 32'h300);
        chk("drop_issue_cnt", {16'd0, issued_cnt}, 32'd15);
        chk("drop_issue_op2", alu_op2,             32'd44);
        apply(1'b1, 1'b0, f_add(5'd14, 5'd13, 5'd13), 32'h304);
        drop = 1'b0;
        chk("drop_nofwd_op1", alu_op1, 32'd0);
        chk("drop_nofwd_op2", alu_op2, 32'd0);
        apply(1'b1, 1'b0, f_add(5'd15, 5'd13, 5'd0), 32'h308);
        chk("drop_nowrite_op1", alu_op1,             32'd0);
        chk("drop_nowrite_cnt", {16'd0, issued_cnt}, 32'd17);

        // Reset in the cycle after an issue
        apply(1'b1, 1'b0, f_addi(5'd16, 5'd0, 12'd77), 32'h400);
        chk("mrst_issue_enable", {31'd0, alu_enable}, 32'd1);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        #3;
        chk("mrst_enable", {31'd0, alu_enable}, 32'd0);
        chk("mrst_instr",  alu_instr,           32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #3;
        chk("mrst_cnt",     {16'd0, issued_cnt}, 32'd0);
        chk("mrst_illegal", {31'd0, illegal},    32'd0);
        chk("mrst_op1",     alu_op1,             32'd0);
        apply(1'b1, 1'b0, f_add(5'd17, 5'd16, 5'd16), 32'h404);
        chk("mrst_x16_op1", alu_op1,             32'd0);
        chk("mrst_x16_op2", alu_op2,             32'd0);
        chk("mrst_x16_en",  {31'd0, alu_enable}, 32'd1);

        // Counter wrap: 1 already counted, add 65534 more to reach FFFF
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        hold     = 1'b0;
        in_instr = f_addi(5'd0, 5'd0, 12'd0);
        repeat (65534) @(posedge clk);
        #1;
        in_valid = 1'b0;
        #3;
        chk("wrap_max", {16'd0, issued_cnt}, 32'h0000FFFF);
        apply(1'b1, 1'b0, f_addi(5'd0, 5'd0, 12'd1), 32'h500);
        chk("wrap_issue_en", {31'd0, alu_enable}, 32'd1);
        apply(1'b0, 1'b0, 32'd0, 32'h0);
        chk("wrap_zero", {16'd0, issued_cnt}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Issue/operand-fetch stage that sits directly upstream of the registered single-cycle ALU in the RV32I integer pipe.
- Accepts decoded RV32I ALU instructions from decode over a valid/ready handshake and reads a local 32x32 register file.
- Builds op1/op2, including sign-extended immediates, and drives the ALU `instr`/`op1`/`op2`/`enable` inputs.
- One cycle after issue, it writes the ALU result back to the register file and forwards it to a dependent follower.

Parameters:
- XLEN, 32, data/register width.
- NREGS, 32, architectural register count; x0 reads as 0 and is never written.
- TRACE, 0, non-zero enables `$display` of each issue; simulation only, excluded under SYNTHESIS.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage accepts `in_instr` this cycle.
- in_instr  in  32  RV32I instruction word.
- in_pc  in  XLEN  PC of `in_instr`.
- hold  in  1  downstream freeze; no issue while high.
- alu_instr  out  32  instruction to ALU.
- alu_op1  out  XLEN  operand 1 to ALU.
- alu_op2  out  XLEN  operand 2 to ALU.
- alu_enable  out  1  ALU executes this cycle.
- alu_result  in  XLEN  registered ALU result.
- alu_instr_exec  in  1  ALU executed last enabled instruction.
- illegal  out  1  one-cycle pulse: accepted word was not an ALU opcode.
- issued_cnt  out  16  count of instructions issued to the ALU.

Behaviour:
- Reset: `alu_enable`=0, `alu_instr`=0, `alu_op1`=0, `alu_op2`=0, `illegal`=0, `issued_cnt`=0, `pend_valid`=0, all registers cleared to 0. Reset mid-flight discards any pending writeback.
- Handshake: `in_ready` = !hold. Transfer occurs when `in_valid && in_ready`.
- Issue timing: the ALU inputs are driven combinationally in the transfer cycle N, with `alu_enable`=1 only in N. `alu_instr` is 0 when not issuing.
- Opcode classes:
  - OP 0110011: op1=rs1, op2=rs2.
  - OP-IMM 0010011: op1=rs1, op2=sext(imm[31:20]). For shifts, only op2[4:0] is meaningful.
  - LUI 0110111: op1={imm[31:12],12'b0}, op2=0.
  - AUIPC 0010111: op1={imm[31:12],12'b0}, op2=in_pc.
  - Any other opcode: accepted and dropped; `alu_enable`=0; `illegal`=1 for one cycle (cycle N+1).
- Pending writeback: on issue, latch `pend_valid`=1 and `pend_rd`=rd at the edge ending N.
  - In cycle N+1, if `pend_valid && alu_instr_exec && pend_rd!=0`, then `regfile[pend_rd]` <= `alu_result` at the edge ending N+1.
  - `pend_valid` clears at the end of N+1 unless a new issue occurs in N+1.
- Forwarding: in the transfer cycle, any rs1/rs2 read with `pend_valid && rs==pend_rd && rs!=0` takes `alu_result` instead of the register file. Back-to-back dependent instructions therefore issue with no stall.
- Dropped write: if `alu_instr_exec`=0 while `pend_valid`=1, the write is dropped and forwarding is suppressed.
- x0 rule: rs==0 always reads 0; rd==0 never writes and never forwards.
- Simultaneous events:
  - `hold` high while `pend_valid` does not block the pending writeback; the write completes regardless.
  - `hold` only blocks new issue; the pending entry then expires after its single writeback cycle.
- Counter: `issued_cnt` increments per ALU issue (illegal words excluded) and wraps from 16'hFFFF to 0.
- Trace: when TRACE is non-zero, `$display` time, PC and instruction on each issue.

Test Plan:
- Basic ADDI: after reset, issue `addi x1,x0,5` then `addi x2,x0,7`, then `add x3,x1,x2` two cycles later -> `alu_op1`=5, `alu_op2`=7, `alu_enable`=1; after writeback `regfile[3]`=12; `issued_cnt`=3.
- Back-to-back forwarding: `addi x1,x0,10` in cycle N, `add x2,x1,x1` in N+1 -> in N+1 `alu_op1`=`alu_op2`=10 taken from `alu_result`, not the stale register value 0.
- Immediates: `addi x4,x0,-1` -> `alu_op2`=32'hFFFFFFFF. `lui x5,0x12345` -> `alu_op1`=32'h12345000, `alu_op2`=0. `auipc` with `in_pc`=32'h100 and imm 0x1 -> `alu_op1`=32'h1000, `alu_op2`=32'h100.
- x0 and illegal: `addi x0,x0,9` followed by `add x6,x0,x0` -> x6 operands both 0 and no forward. Word 32'h0000006F (JAL) -> `alu_enable`=0, `illegal`=1 for exactly one cycle, `issued_cnt` unchanged.
- Hold: `hold`=1 with `in_valid`=1 for 3 cycles -> `in_ready`=0 and `alu_enable`=0 throughout; a writeback pending from the prior cycle still lands. Releasing `hold` issues the held word on the next cycle.
- Reset mid-operation: assert `rst` in the cycle after an issue -> no register written, `pend_valid`=0, all outputs at reset values. Also preset `issued_cnt` to 16'hFFFF and issue once -> `issued_cnt`=0.
